load_store_unit: RTL and testbench

Multi-cycle load/store unit for the memory stage of the 64-bit pipeline. It takes the execute stage's ALU result as the address and its store operand as write data. It drives a request/grant/response data-memory bus with byte-lane enables and returns sign- or zero-extended load data. The pipeline is stalled while an access is in flight.

---
 rtl/load_store_unit.sv | 198 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle load/store unit for the 64-bit memory stage
//
// Purpose:
//   Turns a memory-stage load/store into one request/grant/response bus access.
//   It stalls the pipeline while the access is in flight and returns sign- or
//   zero-extended load data with a one-cycle done_M pulse.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned accesses skip the bus and complete with misaligned_M=1
//   undefined : low address bits are forced to size alignment, misaligned_M tied 0
//
// Ports:
//   clk, reset_n                     clock (rising edge), async active-low reset
//   valid_M, memRead_M, memWrite_M   memory-stage op qualifiers (read wins if both)
//   size_M, unsigned_M               access size (byte/half/word/double), zero-extend
//   address_M, writeData_M           byte address, right-aligned store data
//   stall_M, done_M                  pipeline hold, one-cycle completion pulse
//   readData_M, misaligned_M         completion results, held until the next done
//   mem_req/we/addr/wdata/be         registered bus request fields
//   mem_gnt, mem_rvalid, mem_rdata   bus grant and read response
module load_store_unit #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         valid_M,
    input  logic         memRead_M,
    input  logic         memWrite_M,
    input  logic [1:0]   size_M,
    input  logic         unsigned_M,
    input  logic [N-1:0] address_M,
    input  logic [N-1:0] writeData_M,
    output logic         stall_M,
    output logic         done_M,
    output logic [N-1:0] readData_M,
    output logic         misaligned_M,
    output logic         mem_req,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    output logic [7:0]   mem_be,
    input  logic         mem_gnt,
    input  logic         mem_rvalid,
    input  logic [N-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic           r_is_read;
    logic [1:0]     r_size;
    logic           r_unsigned;
    logic [2:0]     r_off;
    logic           r_mem_req;
    logic           r_mem_we;
    logic [N-1:0]   r_mem_addr;
    logic [N-1:0]   r_mem_wdata;
    logic [7:0]     r_mem_be;
    logic [N-1:0]   r_rdata;

    logic           w_start;
    logic [2:0]     w_align_mask;
    logic [7:0]     w_be_base;
    logic [2:0]     w_off;
    logic           w_trap;
    logic           w_capture;
    logic           w_enter_done;
    logic [N-1:0]   w_shifted;
    logic           w_sign;
    logic [N-1:0]   w_load_ext;

    assign w_start = (r_state == S_IDLE) & valid_M & (memRead_M | memWrite_M);

    // Alignment mask keeps the offset bits that are legal for the access size;
    // the byte-enable base is the lane pattern before shifting into position.
    always_comb begin
        w_align_mask = 3'b111;
        w_be_base    = 8'h01;
        case (size_M)
            2'b00: begin w_align_mask = 3'b111; w_be_base = 8'h01; end
            2'b01: begin w_align_mask = 3'b110; w_be_base = 8'h03; end
            2'b10: begin w_align_mask = 3'b100; w_be_base = 8'h0F; end
            2'b11: begin w_align_mask = 3'b000; w_be_base = 8'hFF; end
            default: begin w_align_mask = 3'b111; w_be_base = 8'h01; end
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_misaligned;
    logic r_misaligned;

    assign w_misaligned = |(address_M[2:0] & ~w_align_mask);
    assign w_off        = address_M[2:0];
    assign w_trap       = w_start & w_misaligned;
    assign misaligned_M = r_misaligned;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_misaligned <= 1'b0;
        end else if (w_enter_done) begin
            r_misaligned <= w_trap;
        end
    end
`else
    assign w_off        = address_M[2:0] & w_align_mask;
    assign w_trap       = 1'b0;
    assign misaligned_M = 1'b0;
`endif

    // A read completes either in a granted REQ cycle with rvalid or in WAIT.
    // Any other rvalid is not ours and is dropped.
    assign w_capture = r_is_read & mem_rvalid &
                       (((r_state == S_REQ) & mem_gnt) | (r_state == S_WAIT));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_start) w_next = w_trap ? S_DONE : S_REQ;
            S_REQ: begin
                if (mem_gnt) begin
                    if (!r_is_read || mem_rvalid) w_next = S_DONE;
                    else                          w_next = S_WAIT;
                end
            end
            S_WAIT: if (mem_rvalid) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_enter_done = (w_next == S_DONE) & (r_state != S_DONE);

    assign w_shifted = mem_rdata >> {r_off, 3'b000};
    assign w_sign    = ~r_unsigned;

    always_comb begin
        w_load_ext = w_shifted;
        case (r_size)
            2'b00: w_load_ext = {{(N-8){w_sign & w_shifted[7]}},   w_shifted[7:0]};
            2'b01: w_load_ext = {{(N-16){w_sign & w_shifted[15]}}, w_shifted[15:0]};
            2'b10: w_load_ext = {{(N-32){w_sign & w_shifted[31]}}, w_shifted[31:0]};
            default: w_load_ext = w_shifted;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_is_read   <= 1'b0;
            r_size      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_off       <= 3'b000;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= 8'h00;
            r_rdata     <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_is_read   <= memRead_M;
                r_size      <= size_M;
                r_unsigned  <= unsigned_M;
                r_off       <= w_off;
                r_mem_req   <= ~w_trap;
                r_mem_we    <= ~memRead_M;
                r_mem_addr  <= {address_M[N-1:3], 3'b000};
                r_mem_wdata <= writeData_M << {w_off, 3'b000};
                r_mem_be    <= memRead_M ? 8'h00 : (w_be_base << w_off);
            end
            if ((r_state == S_REQ) && mem_gnt) begin
                r_mem_req <= 1'b0;
            end
            // Stores and trapped accesses report zero load data.
            if (w_enter_done) begin
                r_rdata <= w_capture ? w_load_ext : '0;
            end
        end
    end

    assign stall_M    = reset_n & (w_start | (r_state == S_REQ) | (r_state == S_WAIT));
    assign done_M     = (r_state == S_DONE);
    assign readData_M = r_rdata;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_be     = r_mem_be;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid_M, memRead_M, memWrite_M, unsigned_M;
    logic [1:0]  size_M;
    logic [63:0] address_M, writeData_M;
    logic        stall_M, done_M, misaligned_M;
    logic [63:0] readData_M;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_be;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    load_store_unit #(.N(64)) dut (
        .clk(clk), .reset_n(reset_n),
        .valid_M(valid_M), .memRead_M(memRead_M), .memWrite_M(memWrite_M),
        .size_M(size_M), .unsigned_M(unsigned_M),
        .address_M(address_M), .writeData_M(writeData_M),
        .stall_M(stall_M), .done_M(done_M),
        .readData_M(readData_M), .misaligned_M(misaligned_M),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Reference load result: select the bytes, then extend from the top bit.
    function automatic logic [63:0] ext_load(logic [63:0] raw, int off, int bytes, bit uns);
        logic [63:0] v;
        logic [63:0] m;
        v = raw >> (8 * off);
        if (bytes == 8) return v;
        m = (64'd1 << (8 * bytes)) - 64'd1;
        v = v & m;
        if (!uns && v[8*bytes-1]) v = v | ~m;
        return v;
    endfunction

    // One access with the grant arriving gd cycles late and read data rvd
    // cycles after the grant; every expectation comes from the model above.
    task automatic do_access(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                             input logic [63:0] a, input logic [63:0] wd,
                             input logic [63:0] rdata, input int gd, input int rvd);
        int          bytes, off, eoff, gnt_c, rv_c, done_c;
        bit          mis, trap;
        logic [7:0]  exp_be;
        logic [63:0] exp_wd, exp_rd;
        bytes = 1 << sz;
        off   = int'(a[2:0]);
        mis   = (off % bytes) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
        trap  = mis;
`else
        trap  = 1'b0;
`endif
        eoff   = trap ? off : off - (off % bytes);
        exp_be = rd ? 8'h00 : 8'(((1 << bytes) - 1) << eoff);
        exp_wd = wd << (8 * eoff);
        exp_rd = (rd && !trap) ? ext_load(rdata, eoff, bytes, uns) : 64'd0;
        gnt_c  = 1 + gd;
        rv_c   = gnt_c + rvd;
        done_c = trap ? 1 : (rd ? rv_c + 1 : gnt_c + 1);

        @(negedge clk);
        valid_M = 1'b1; memRead_M = rd; memWrite_M = wr; size_M = sz; unsigned_M = uns;
        address_M = a; writeData_M = wd; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        #1;
        chk("stall_at_accept", stall_M, 1'b1);
        for (int c = 1; c <= done_c; c++) begin
            @(negedge clk);
            chk("mem_req", mem_req, (!trap && c <= gnt_c));
            chk("stall_M", stall_M, (c < done_c));
            chk("done_M", done_M, (c == done_c));
            if (!trap && c <= gnt_c) begin
                chk("mem_addr", mem_addr, a & ~64'd7);
                chk("mem_we", mem_we, wr && !rd);
                chk("mem_be", mem_be, exp_be);
                chk("mem_wdata", mem_wdata, exp_wd);
            end
            if (c == done_c) begin
                if (rd || trap) chk("readData_M", readData_M, exp_rd);
                chk("misaligned_M", misaligned_M, trap);
                valid_M = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
            end else begin
                mem_gnt = !trap && (c == gnt_c);
                if (rd && c == rv_c) begin
                    mem_rvalid = 1'b1; mem_rdata = rdata;
                end else if (!rd || c < gnt_c) begin
                    mem_rvalid = 1'($urandom_range(0, 1));
                    mem_rdata  = {$urandom, $urandom};
                end else begin
                    mem_rvalid = 1'b0;
                end
            end
        end
        @(negedge clk);
        chk("done_single_pulse", done_M, 1'b0);
        chk("stall_after_done", stall_M, 1'b0);
        chk("req_after_done", mem_req, 1'b0);
        if (rd || trap) chk("readData_hold", readData_M, exp_rd);
    endtask

    task automatic reset_mid(input bit in_wait);
        @(negedge clk);
        valid_M = 1'b1; memRead_M = 1'b1; memWrite_M = 1'b0; size_M = 2'b10; unsigned_M = 1'b0;
        address_M = 64'h6000; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        chk("rst_req_before", mem_req, 1'b1);
        if (in_wait) begin
            mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt = 1'b0;
            chk("rst_stall_in_wait", stall_M, 1'b1);
        end
        reset_n = 1'b0;
        #1;
        chk("rst_req_drop", mem_req, 1'b0);
        chk("rst_stall_drop", stall_M, 1'b0);
        chk("rst_done_low", done_M, 1'b0);
        valid_M = 1'b0; memRead_M = 1'b0;
        @(negedge clk);
        reset_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = {$urandom, $urandom};
        @(negedge clk);
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rst_late_rvalid_no_done", done_M, 1'b0);
            chk("rst_late_rvalid_no_stall", stall_M, 1'b0);
            @(negedge clk);
        end
    endtask

    initial begin
        bit          rd, wr;
        logic [1:0]  sz;
        reset_n = 1'b0; valid_M = 1'b0; memRead_M = 1'b0; memWrite_M = 1'b0;
        size_M = 2'b00; unsigned_M = 1'b0; address_M = '0; writeData_M = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_stall", stall_M, 1'b0);
        chk("reset_done", done_M, 1'b0);
        chk("reset_readData", readData_M, 64'd0);
        chk("reset_misaligned", misaligned_M, 1'b0);
        chk("reset_mem_req", mem_req, 1'b0);
        chk("reset_mem_we", mem_we, 1'b0);
        chk("reset_mem_addr", mem_addr, 64'd0);
        chk("reset_mem_wdata", mem_wdata, 64'd0);
        chk("reset_mem_be", mem_be, 8'h00);
        reset_n = 1'b1;

        // Store byte with immediate grant.
        do_access(1'b0, 1'b1, 2'b00, 1'b0, 64'h1003, 64'hAB, 64'd0, 0, 0);
        // Signed and unsigned half loads from the top lanes.
        do_access(1'b1, 1'b0, 2'b01, 1'b0, 64'h2006, 64'd0, 64'h8001_0000_0000_0000, 0, 0);
        chk("half_signed_const", readData_M, 64'hFFFF_FFFF_FFFF_8001);
        do_access(1'b1, 1'b0, 2'b01, 1'b1, 64'h2006, 64'd0, 64'h8001_0000_0000_0000, 0, 0);
        chk("half_unsigned_const", readData_M, 64'h0000_0000_0000_8001);
        // Word load with slow grant and slow response.
        do_access(1'b1, 1'b0, 2'b10, 1'b0, 64'h3004, 64'd0, 64'hDEAD_BEEF_1234_5678, 3, 2);
        // Double load at a misaligned address.
        do_access(1'b1, 1'b0, 2'b11, 1'b0, 64'h4004, 64'd0, 64'h0123_4567_89AB_CDEF, 1, 0);
        // Read and write both set: read wins.
        do_access(1'b1, 1'b1, 2'b10, 1'b1, 64'h5000, 64'hFFFF_FFFF, 64'h0000_0000_F00D_CAFE, 0, 1);
        // Delayed store grant.
        do_access(1'b0, 1'b1, 2'b11, 1'b0, 64'h7000, 64'h1122_3344_5566_7788, 64'd0, 2, 0);

        reset_mid(1'b1);
        reset_mid(1'b0);

        for (int i = 0; i < 40; i++) begin
            rd = 1'($urandom_range(0, 1));
            wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            sz = 2'($urandom_range(0, 3));
            do_access(rd, wr, sz, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                      {$urandom, $urandom}, {$urandom, $urandom},
                      $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
